// File: rtl/branch_predictor_if.sv
// Fetch-redirect bundle between the pipeline and branch_predictor.
// The predictor sits on the slave modport; the pipeline (or a bench) drives
// the master modport. Optional perf counters ride along on the same bundle.
interface branch_predictor_if #(
  parameter int addrWidth = 16
);

  // Pipeline-side inputs to the predictor
  logic                 Hcf;
  logic                 Stall;
  logic [addrWidth-1:0] IF_pc;
  logic                 EXE_valid;
  logic                 EXE_is_branch;
  logic                 EXE_taken;
  logic [addrWidth-1:0] EXE_pc;
  logic [addrWidth-1:0] EXE_Target_pc;
  logic                 EXE_pred_taken;
  logic [addrWidth-1:0] EXE_pred_target;

  // Predictor-side outputs to the PC register / pipeline
  logic [1:0]           PCSel;
  logic [addrWidth-1:0] Predict_Target_pc;
  logic                 IF_pred_taken;
  logic                 Flush;
  logic [31:0]          branch_cnt;
  logic [31:0]          mispred_cnt;

  modport slave (
    input  Hcf, Stall, IF_pc,
    input  EXE_valid, EXE_is_branch, EXE_taken, EXE_pc, EXE_Target_pc,
    input  EXE_pred_taken, EXE_pred_target,
    output PCSel, Predict_Target_pc, IF_pred_taken, Flush,
    output branch_cnt, mispred_cnt
  );

  modport master (
    output Hcf, Stall, IF_pc,
    output EXE_valid, EXE_is_branch, EXE_taken, EXE_pc, EXE_Target_pc,
    output EXE_pred_taken, EXE_pred_target,
    input  PCSel, Predict_Target_pc, IF_pred_taken, Flush,
    input  branch_cnt, mispred_cnt
  );

endinterface

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit saturating counters.
// IF side: zero-latency lookup of IF_pc, predicts taken transfers.
// EXE side: compares resolved outcome with the carried prediction, issues
// redirect + Flush on mismatch and trains the BTB at the clock edge.
// Optional feature macro: BP_PERF_CNT_EN builds branch/mispredict counters;
// without it both counter outputs are tied to zero.
//
// PCSel codes (shared rv32_define encodings):
//   2'd0 sequential pc+4, 2'd1 IF_P_T_PC, 2'd2 EXE_PC_PLUS_4, 2'd3 EXE_T_PC
//
// Interface timing: there is no valid/ready handshake. IF_pc and the EXE
// fields are sampled combinationally every cycle; EXE_valid qualifies the
// EXE slot, Stall/Hcf only gate state updates, never the redirect outputs.
module branch_predictor #(
  parameter int addrWidth = 16,
  parameter int IDX_BITS  = 4
) (
  input logic               clk,
  input logic               rst,
  branch_predictor_if.slave bp
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = addrWidth - IDX_BITS - 2;

  localparam logic [1:0] PC_PLUS_4     = 2'd0;
  localparam logic [1:0] IF_P_T_PC     = 2'd1;
  localparam logic [1:0] EXE_PC_PLUS_4 = 2'd2;
  localparam logic [1:0] EXE_T_PC      = 2'd3;

  // BTB storage
  logic                 btb_valid  [ENTRIES];
  logic [TAG_W-1:0]     btb_tag    [ENTRIES];
  logic [addrWidth-1:0] btb_target [ENTRIES];
  logic [1:0]           btb_ctr    [ENTRIES];

  logic [IDX_BITS-1:0] if_idx;
  logic [TAG_W-1:0]    if_tag;
  logic                if_hit;
  logic [IDX_BITS-1:0] exe_idx;
  logic [TAG_W-1:0]    exe_tag;
  logic                exe_hit;

  logic res;
  logic mis_t;
  logic mis_nt;
  logic train;

  // pc[1:0] never participates in index or tag
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bp.IF_pc[1:0], bp.EXE_pc[1:0]};

  assign if_idx  = bp.IF_pc[IDX_BITS+1:2];
  assign if_tag  = bp.IF_pc[addrWidth-1:IDX_BITS+2];
  assign if_hit  = btb_valid[if_idx] && (btb_tag[if_idx] == if_tag);

  assign exe_idx = bp.EXE_pc[IDX_BITS+1:2];
  assign exe_tag = bp.EXE_pc[addrWidth-1:IDX_BITS+2];
  assign exe_hit = btb_valid[exe_idx] && (btb_tag[exe_idx] == exe_tag);

  // A valid non-branch carrying a taken prediction came from an aliased BTB
  // hit; it is redirected like a not-taken mispredict but never trains.
  assign res    = bp.EXE_valid & bp.EXE_is_branch;
  assign mis_t  = res & bp.EXE_taken &
                  (~bp.EXE_pred_taken | (bp.EXE_pred_target != bp.EXE_Target_pc));
  assign mis_nt = (res & ~bp.EXE_taken & bp.EXE_pred_taken) |
                  (bp.EXE_valid & ~bp.EXE_is_branch & bp.EXE_pred_taken);
  assign train  = res & ~bp.Stall & ~bp.Hcf;

  // Prediction / redirect outputs; reset forces the idle values
  always_comb begin
    bp.PCSel             = PC_PLUS_4;
    bp.Flush             = 1'b0;
    bp.IF_pred_taken     = 1'b0;
    bp.Predict_Target_pc = '0;
    if (!rst) begin
      bp.IF_pred_taken     = if_hit & btb_ctr[if_idx][1];
      bp.Predict_Target_pc = if_hit ? btb_target[if_idx] : '0;
      bp.Flush             = mis_t | mis_nt;
      if (mis_t)                 bp.PCSel = EXE_T_PC;
      else if (mis_nt)           bp.PCSel = EXE_PC_PLUS_4;
      else if (bp.IF_pred_taken) bp.PCSel = IF_P_T_PC;
      else                       bp.PCSel = PC_PLUS_4;
    end
  end

  // BTB clear on reset, training on resolved branches otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
        btb_ctr[i]    <= 2'b01;
      end
    end else if (train) begin
      if (exe_hit) begin
        if (bp.EXE_taken) begin
          btb_ctr[exe_idx]    <= (btb_ctr[exe_idx] == 2'b11) ? 2'b11 : btb_ctr[exe_idx] + 2'b01;
          btb_target[exe_idx] <= bp.EXE_Target_pc;
        end else begin
          btb_ctr[exe_idx]    <= (btb_ctr[exe_idx] == 2'b00) ? 2'b00 : btb_ctr[exe_idx] - 2'b01;
        end
      end else if (bp.EXE_taken) begin
        btb_valid[exe_idx]  <= 1'b1;
        btb_tag[exe_idx]    <= exe_tag;
        btb_target[exe_idx] <= bp.EXE_Target_pc;
        btb_ctr[exe_idx]    <= 2'b10;
      end
    end
  end

`ifdef BP_PERF_CNT_EN
  logic [31:0] branch_cnt_q;
  logic [31:0] mispred_cnt_q;

  // Performance counters advance on training events only, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else if (train) begin
      branch_cnt_q <= branch_cnt_q + 32'd1;
      if (mis_t | mis_nt) mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

  assign bp.branch_cnt  = branch_cnt_q;
  assign bp.mispred_cnt = mispred_cnt_q;
`else
  assign bp.branch_cnt  = 32'd0;
  assign bp.mispred_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: expected outputs are pushed onto a
// scoreboard queue as each step is driven, then popped and compared.
module tb_branch_predictor;

  localparam int AW = 16;

  localparam logic [1:0] C_PC4  = 2'd0;
  localparam logic [1:0] C_IFPT = 2'd1;
  localparam logic [1:0] C_EXP4 = 2'd2;
  localparam logic [1:0] C_EXT  = 2'd3;

`ifdef BP_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk;
  logic rst;

  branch_predictor_if #(.addrWidth(AW)) bp_if ();

  branch_predictor #(.addrWidth(AW), .IDX_BITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp_if)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // scoreboard state: {PCSel, Flush, IF_pred_taken, Predict_Target_pc}
  logic [19:0] exp_q[$];
  logic [63:0] cnt_q[$];
  int vectors     = 0;
  int miscompares = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_exe(input logic v, input logic br, input logic tk,
                           input logic [AW-1:0] pc, input logic [AW-1:0] tgt,
                           input logic ptk, input logic [AW-1:0] ptgt);
    bp_if.EXE_valid       = v;
    bp_if.EXE_is_branch   = br;
    bp_if.EXE_taken       = tk;
    bp_if.EXE_pc          = pc;
    bp_if.EXE_Target_pc   = tgt;
    bp_if.EXE_pred_taken  = ptk;
    bp_if.EXE_pred_target = ptgt;
  endtask

  task automatic idle_exe();
    drive_exe(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic expect_out(input logic [1:0] pcsel, input logic flush,
                            input logic pred, input logic [AW-1:0] tgt);
    exp_q.push_back({pcsel, flush, pred, tgt});
  endtask

  task automatic expect_cnt(input logic [31:0] br, input logic [31:0] mis);
    cnt_q.push_back(PERF ? {br, mis} : 64'd0);
  endtask

  task automatic check_out(input string tag);
    logic [19:0] exp;
    logic [19:0] obs;
    #2;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s: observed=empty-queue required=entry", tag);
    end else begin
      exp = exp_q.pop_front();
      obs = {bp_if.PCSel, bp_if.Flush, bp_if.IF_pred_taken, bp_if.Predict_Target_pc};
      assert (obs === exp) else begin
        miscompares++;
        $error("FAIL %s: observed={sel=%0d fl=%0b pt=%0b tgt=%h} required={sel=%0d fl=%0b pt=%0b tgt=%h}",
               tag, obs[19:18], obs[17], obs[16], obs[15:0],
               exp[19:18], exp[17], exp[16], exp[15:0]);
      end
    end
  endtask

  task automatic check_cnt(input string tag);
    logic [63:0] exp;
    logic [63:0] obs;
    #1;
    vectors++;
    if (cnt_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s: observed=empty-queue required=entry", tag);
    end else begin
      exp = cnt_q.pop_front();
      obs = {bp_if.branch_cnt, bp_if.mispred_cnt};
      assert (obs === exp) else begin
        miscompares++;
        $error("FAIL %s: observed=br %0d mis %0d required=br %0d mis %0d",
               tag, obs[63:32], obs[31:0], exp[63:32], exp[31:0]);
      end
    end
  endtask

  initial begin
    logic [AW-1:0] rpc;

    rst          = 1'b1;
    bp_if.Hcf    = 1'b0;
    bp_if.Stall  = 1'b0;
    bp_if.IF_pc  = '0;
    idle_exe();

    // Reset forces idle outputs even with a taken mispredict in EXE
    tick();
    bp_if.IF_pc = 16'h0044;
    drive_exe(1'b1, 1'b1, 1'b1, 16'h0044, 16'h0500, 1'b0, '0);
    expect_out(C_PC4, 1'b0, 1'b0, '0);
    check_out("reset_forced");
    expect_cnt(0, 0);
    check_cnt("reset_cnt");
    tick();
    rst = 1'b0;
    idle_exe();
    expect_out(C_PC4, 1'b0, 1'b0, '0);
    check_out("reset_discards_train");

    // Test plan 1: cold lookup misses
    bp_if.IF_pc = 16'h0040;
    expect_out(C_PC4, 1'b0, 1'b0, '0);
    check_out("cold_miss_0040");

    // Random fetch addresses all miss on an empty BTB
    for (int i = 0; i < 4; i++) begin
      rpc = 16'($urandom_range(0, 16'hFFFF));
      bp_if.IF_pc = rpc;
      expect_out(C_PC4, 1'b0, 1'b0, '0);
      check_out("rand_cold_miss");
    end

    // Test plan 2: taken branch not predicted -> EXE_T_PC + flush, allocate
    bp_if.IF_pc = 16'h0040;
    drive_exe(1'b1, 1'b1, 1'b1, 16'h0040, 16'h0100, 1'b0, '0);
    expect_out(C_EXT, 1'b1, 1'b0, '0);
    check_out("mis_t_alloc");
    tick();
    idle_exe();
    expect_out(C_IFPT, 1'b0, 1'b1, 16'h0100);
    check_out("hit_after_alloc");
    expect_cnt(1, 1);
    check_cnt("cnt_after_alloc");

    // Test plan 3: two not-taken resolutions drive ctr 2 -> 1 -> 0
    bp_if.IF_pc = 16'h0000;
    drive_exe(1'b1, 1'b1, 1'b0, 16'h0040, 16'h0100, 1'b1, 16'h0100);
    expect_out(C_EXP4, 1'b1, 1'b0, '0);
    check_out("mis_nt_first");
    tick();
    expect_out(C_EXP4, 1'b1, 1'b0, '0);
    check_out("mis_nt_second");
    tick();
    idle_exe();
    bp_if.IF_pc = 16'h0040;
    expect_out(C_PC4, 1'b0, 1'b0, 16'h0100);
    check_out("ctr_zero_no_pred");
    expect_cnt(3, 3);
    check_cnt("cnt_after_nt");

    // Test plan 4: same index, different tag -> miss, then JAL replaces entry
    bp_if.IF_pc = 16'h0080;
    expect_out(C_PC4, 1'b0, 1'b0, '0);
    check_out("alias_miss_0080");
    drive_exe(1'b1, 1'b1, 1'b1, 16'h0080, 16'h0200, 1'b0, '0);
    expect_out(C_EXT, 1'b1, 1'b0, '0);
    check_out("jal_mis_t_0080");
    tick();
    idle_exe();
    bp_if.IF_pc = 16'h0040;
    expect_out(C_PC4, 1'b0, 1'b0, '0);
    check_out("replaced_0040_miss");
    bp_if.IF_pc = 16'h0080;
    expect_out(C_IFPT, 1'b0, 1'b1, 16'h0200);
    check_out("replaced_0080_hit");

    // Test plan 5a: mis_nt in EXE outranks a predicted-taken IF hit
    tick();
    drive_exe(1'b1, 1'b1, 1'b0, 16'h0044, 16'h0300, 1'b1, 16'h0300);
    expect_out(C_EXP4, 1'b1, 1'b1, 16'h0200);
    check_out("mis_nt_over_if_hit");
    tick();
    // Aliased non-branch with a taken prediction: redirect, no training
    drive_exe(1'b1, 1'b0, 1'b0, 16'h0080, 16'h0000, 1'b1, 16'h0200);
    expect_out(C_EXP4, 1'b1, 1'b1, 16'h0200);
    check_out("nonbranch_alias_redirect");
    tick();
    idle_exe();
    expect_out(C_IFPT, 1'b0, 1'b1, 16'h0200);
    check_out("nonbranch_no_train");
    expect_cnt(5, 5);
    check_cnt("cnt_after_alias");

    // Test plan 6: Hcf holds state but redirect still fires
    bp_if.Hcf = 1'b1;
    drive_exe(1'b1, 1'b1, 1'b0, 16'h0080, 16'h0200, 1'b1, 16'h0200);
    expect_out(C_EXP4, 1'b1, 1'b1, 16'h0200);
    check_out("hcf_flush");
    tick();
    tick();
    bp_if.Hcf = 1'b0;
    idle_exe();
    expect_out(C_IFPT, 1'b0, 1'b1, 16'h0200);
    check_out("hcf_btb_unchanged");
    expect_cnt(5, 5);
    check_cnt("hcf_cnt_unchanged");

    // One-cycle reset clears BTB and counters
    rst = 1'b1;
    tick();
    expect_out(C_PC4, 1'b0, 1'b0, '0);
    check_out("rst_pulse_forced");
    rst = 1'b0;
    tick();
    expect_out(C_PC4, 1'b0, 1'b0, '0);
    check_out("rst_pulse_cleared");
    expect_cnt(0, 0);
    check_cnt("rst_pulse_cnt");

    // Test plan 5b: stall 3 cycles, branch trains exactly once
    bp_if.IF_pc = 16'h0048;
    bp_if.Stall = 1'b1;
    drive_exe(1'b1, 1'b1, 1'b1, 16'h0048, 16'h0300, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      expect_out(C_EXT, 1'b1, 1'b0, '0);
      check_out("stall_redirect");
      tick();
    end
    bp_if.Stall = 1'b0;
    expect_out(C_EXT, 1'b1, 1'b0, '0);
    check_out("stall_release");
    tick();
    idle_exe();
    expect_out(C_IFPT, 1'b0, 1'b1, 16'h0300);
    check_out("stall_trained");
    expect_cnt(1, 1);
    check_cnt("stall_cnt_once");
    // One not-taken step from ctr=2 must drop below the taken threshold
    drive_exe(1'b1, 1'b1, 1'b0, 16'h0048, 16'h0300, 1'b1, 16'h0300);
    bp_if.IF_pc = 16'h0000;
    expect_out(C_EXP4, 1'b1, 1'b0, '0);
    check_out("stall_followup_mis_nt");
    tick();
    idle_exe();
    bp_if.IF_pc = 16'h0048;
    expect_out(C_PC4, 1'b0, 1'b0, 16'h0300);
    check_out("stall_single_step");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
